// File: rtl/mdu_pkg.sv
// Shared types and helpers for the M-extension multiply/divide sequencer.
//   mdu_op_e    : funct3 encodings of the eight M-extension ops
//   mdu_state_e : sequencer FSM states
//   MDU_IS_DIV  : true for DIV/DIVU/REM/REMU (funct3 bit 2)
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

  function automatic logic MDU_IS_DIV(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step, purely combinational.
// The partial remainder and the next dividend bit are shifted together and the
// divisor is trial-subtracted; a non-negative difference is kept and sets the
// quotient bit, otherwise the shifted remainder is restored.
//   rem_i / rem_o : partial remainder, XLEN+1 bits (in / out)
//   quo_i / quo_o : dividend bits still to consume, quotient bits shifted in
//   dvs_i         : divisor magnitude
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    trial   = shifted - {2'b00, dvs_i};
    if (!trial[XLEN+1]) begin
      rem_o = trial[XLEN:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Sequencer for the M-extension multiply/divide unit in the EXE stage.
// Accepts one MUL/DIV/REM op, runs the multi-cycle multiplier or the
// iterative restoring divider, holds the pipeline through exe_hazard and
// presents the XLEN result with resp_valid in DONE.
//   clk, rstn        : core clock, asynchronous active-low reset
//   req, op          : EXE holds a valid M-op (funct3 in op)
//   rs1, rs2         : operands, sampled only on accept
//   exe_stall        : EXE held by another hazard (keeps DONE)
//   exe_kill         : EXE flushed, aborts any op in flight
//   exe_hazard       : stall request to the hazard unit (combinational)
//   resp_valid       : result valid (DONE)
//   result           : op result
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            exe_stall,
  input  logic            exe_kill,
  output logic            exe_hazard,
  output logic            resp_valid,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    return neg ? -v : v;
  endfunction

  // control state (reset)
  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // datapath state (no reset, only meaningful after accept)
  logic              want_hi_q, want_hi_d;
  logic              want_rem_q, want_rem_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [2*XLEN-1:0] prod_q, prod_d;

  // accept-cycle operand preparation
  logic                     a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]          abs_a, abs_b;
  logic                     a_sext, b_sext;
  logic signed [2*XLEN-1:0] mul_a, mul_b, mul_full;
  logic [XLEN:0]            step_rem;
  logic [XLEN-1:0]          step_quo;

  always_comb begin
    // op[0] set marks the unsigned divide forms
    a_neg    = !op[0] && rs1[XLEN-1];
    b_neg    = !op[0] && rs2[XLEN-1];
    abs_a    = cond_neg(rs1, a_neg);
    abs_b    = cond_neg(rs2, b_neg);
    div_zero = (rs2 == '0);
    div_ovf  = !op[0] && (rs1 == MIN_VAL) && (rs2 == '1);
    // MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed;
    // the low half used by MUL is the same either way.
    a_sext   = (op[1:0] != 2'b11);
    b_sext   = (op[1:0] == 2'b01);
    mul_a    = {{XLEN{a_sext & rs1[XLEN-1]}}, rs1};
    mul_b    = {{XLEN{b_sext & rs2[XLEN-1]}}, rs2};
    mul_full = mul_a * mul_b;
  end

  mdu_div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    want_hi_d  = want_hi_q;
    want_rem_d = want_rem_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    prod_d     = prod_q;
    exe_hazard = 1'b0;
    resp_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req && !exe_kill) begin
          exe_hazard = 1'b1;
          want_hi_d  = (op[1:0] != 2'b00);
          want_rem_d = op[1];
          if (MDU_IS_DIV(op)) begin
            if (div_zero) begin
              result_d = op[1] ? rs1 : '1;
              state_d  = S_DONE;
            end else if (div_ovf) begin
              result_d = op[1] ? '0 : MIN_VAL;
              state_d  = S_DONE;
            end else begin
              rem_d     = '0;
              quo_d     = abs_a;
              dvs_d     = abs_b;
              quo_neg_d = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              cnt_d     = CNT_W'(XLEN - 1);
              state_d   = S_DIV;
            end
          end else begin
            prod_d  = mul_full;
            cnt_d   = CNT_W'(MUL_LAT - 1);
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        exe_hazard = 1'b1;
        if (cnt_q == '0) begin
          result_d = want_hi_q ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        exe_hazard = 1'b1;
        rem_d      = step_rem;
        quo_d      = step_quo;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FIX: begin
        exe_hazard = 1'b1;
        result_d   = want_rem_q ? cond_neg(rem_q[XLEN-1:0], rem_neg_q)
                                : cond_neg(quo_q, quo_neg_q);
        state_d    = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (!exe_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // a flush abandons the op outright, including an already finished one
    if (exe_kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    want_hi_q  <= want_hi_d;
    want_rem_q <= want_rem_d;
    rem_q      <= rem_d;
    quo_q      <= quo_d;
    dvs_q      <= dvs_d;
    quo_neg_q  <= quo_neg_d;
    rem_neg_q  <= rem_neg_d;
    prod_q     <= prod_d;
  end

  assign result = result_q;

endmodule
